// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, small instruction FIFO, branch redirect/flush.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/flush_count performance counters.
module fetch_stage #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_after;
  logic [ADDR_W-1:0]  fifo_pc   [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic               push, pop;

  // A redirect cancels both the returning word and any pop in the same cycle.
  assign push        = (state_reg == BUSY) && imem_ack && !pc_src;
  assign pop         = inst_valid && inst_ready && !pc_src;
  assign count_after = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (!pc_src && count_reg < DEPTH_C) begin
          state_next = BUSY;
          addr_next  = fetch_pc_reg;
        end
      end
      BUSY: begin
        if (pc_src) begin
          state_next = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
          if (count_after < DEPTH_C) begin
            state_next = BUSY;
            addr_next  = fetch_pc_reg + ADDR_W'(4);
          end else begin
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (pc_src) fetch_pc_next = branch_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      if (pc_src) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_after;
      end
    end
  end

  // Storage needs no reset: entries are only visible behind count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_reg]   <= fetch_pc_reg;
      fifo_data[wr_ptr_reg] <= imem_rdata;
    end
  end

  assign imem_req   = (state_reg != IDLE);
  assign imem_addr  = addr_reg;
  assign inst_valid = (count_reg != '0);
  assign instr      = inst_valid ? fifo_data[rd_ptr_reg] : '0;
  assign pc_out     = inst_valid ? fifo_pc[rd_ptr_reg] : '0;
  assign cond       = instr[31:28];
  assign op         = instr[27:26];
  assign funct      = instr[25:20];
  assign rd         = instr[15:12];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [15:0] flush_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (pop && fetch_count_reg != '1)    fetch_count_reg <= fetch_count_reg + 32'd1;
      if (pc_src && flush_count_reg != '1) flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the expected stream is the program-order PC sequence
// restarted at each redirect/reset; a negedge monitor pops it on every accepted instruction.
module tb_fetch_stage;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_src(pc_src), .branch_target(branch_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instr(instr), .pc_out(pc_out),
    .cond(cond), .op(op), .funct(funct), .rd(rd)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RST_PC;
  int          mem_mode = 0;
  int          lat_cfg = 0;
  bit          lat_rand = 0;
  int          mem_lat = 0;
  bit          mem_pend = 0;
  bit          prev_pend = 0;
  logic [31:0] prev_addr = '0;
  int          pops_seen = 0;
  int          flushes_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction memory contents: mode 0 returns the address, mode 1 a scrambled word.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (mem_mode == 0) return a;
    if (a == 32'h0) return 32'hE0812003;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, answer imem, and keep the expected PC stream topped up.
  task automatic drive(input logic rdy, input logic src, input logic [31:0] tgt);
    inst_ready    = rdy;
    pc_src        = src;
    branch_target = tgt;
    if (imem_req) begin
      if (!mem_pend) mem_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      if (mem_lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_fn(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_lat--;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
    mem_pend = imem_req && !imem_ack;
    if (src) begin
      exp_q.delete();
      model_pc = tgt;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_ready = 1'b0; pc_src = 1'b0; imem_ack = 1'b0; branch_target = '0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    exp_q.delete();
    model_pc = RST_PC;
    mem_pend = 0; mem_lat = 0;
    pops_seen = 0; flushes_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    tick();
    while (!inst_valid && n < 50) begin
      drive(1'b1, 1'b0, '0);
      tick();
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: inst_valid never rose within 50 cycles", nm);
    end
  endtask

  // Monitor: checks request hold, idle zeroing and every accepted instruction.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_pend = 0;
    end else begin
      if (prev_pend) begin
        chk("hold_req", {31'b0, imem_req}, 32'd1);
        chk("hold_addr", imem_addr, prev_addr);
      end
      if (!inst_valid) begin
        chk("idle_instr", instr, 32'd0);
        chk("idle_pc", pc_out, 32'd0);
        chk("idle_fields", {16'b0, cond, op, funct, rd}, 32'd0);
      end else if (inst_ready && !pc_src) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h expected no instruction", pc_out);
        end else begin
          logic [31:0] ep;
          logic [31:0] ed;
          ep = exp_q.pop_front();
          ed = mem_fn(ep);
          chk("pop_pc", pc_out, ep);
          chk("pop_instr", instr, ed);
          chk("pop_fields", {16'b0, cond, op, funct, rd},
              {16'b0, ed[31:28], ed[27:26], ed[25:20], ed[15:12]});
          $display("pop pc=%h instr=%h", pc_out, instr);
        end
        pops_seen++;
      end
      if (pc_src) flushes_seen++;
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acks;
    int n;
    bit sustained;
    bit seen0;
    logic [31:0] tgt;

    #2;
    do_reset();

    // Zero-wait memory, data == address, always ready
    mem_mode = 0; lat_rand = 0; lat_cfg = 0;
    drive(1'b1, 1'b0, '0);
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    drive(1'b1, 1'b0, '0);
    wait_valid("a_valid");
    chk("a_first_pc", pc_out, RST_PC);
    sustained = 1;
    for (int i = 0; i < 10; i++) begin
      if (!inst_valid) sustained = 0;
      drive(1'b1, 1'b0, '0);
      tick();
    end
    chk("a_sustained", {31'b0, sustained}, 32'd1);

    // Field split of a known word at address 0
    mem_mode = 1;
    drive(1'b1, 1'b1, 32'h0);
    wait_valid("b_valid");
    chk("b_pc", pc_out, 32'h0);
    chk("b_cond", {28'b0, cond}, 32'hE);
    chk("b_op", {30'b0, op}, 32'h0);
    chk("b_funct", {26'b0, funct}, 32'h08);
    chk("b_rd", {28'b0, rd}, 32'h2);

    // Downstream stall: exactly DEPTH words buffered, then drained in order
    drive(1'b0, 1'b1, 32'h200);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b0, 1'b0, '0);
      if (imem_ack) acks++;
    end
    tick();
    chk("c_acks", acks, DEPTH);
    chk("c_req", {31'b0, imem_req}, 32'd0);
    chk("c_valid", {31'b0, inst_valid}, 32'd1);
    chk("c_head", pc_out, 32'h200);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, '0);
      tick();
    end

    // Redirect while the request to 0x8 is waiting on memory
    lat_cfg = 3;
    drive(1'b1, 1'b1, 32'h0);
    n = 0;
    tick();
    while (!(imem_req && imem_addr == 32'h8 && !mem_pend) && n < 60) begin
      drive(1'b1, 1'b0, '0);
      tick();
      n++;
    end
    chk("d_req8", imem_addr, 32'h8);
    drive(1'b1, 1'b1, 32'h100);
    chk("d_noack", {31'b0, imem_ack}, 32'd0);
    n = 0;
    while (!imem_ack && n < 10) begin
      tick();
      chk("d_drop_addr", imem_addr, 32'h8);
      drive(1'b1, 1'b0, '0);
      n++;
    end
    tick();
    chk("d_idle", {31'b0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, '0);
    tick();
    chk("d_req", {31'b0, imem_req}, 32'd1);
    chk("d_addr", imem_addr, 32'h100);
    drive(1'b1, 1'b0, '0);
    wait_valid("d_valid");
    chk("d_pc", pc_out, 32'h100);

    // Redirect coincident with ack and pop
    lat_cfg = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, '0);
      tick();
    end
    chk("e_pre_valid", {31'b0, inst_valid}, 32'd1);
    chk("e_pre_req", {31'b0, imem_req}, 32'd1);
    drive(1'b1, 1'b1, 32'h300);
    chk("e_pre_ack", {31'b0, imem_ack}, 32'd1);
    tick();
    chk("e_valid", {31'b0, inst_valid}, 32'd0);
    chk("e_req", {31'b0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, '0);
    tick();
    chk("e_req2", {31'b0, imem_req}, 32'd1);
    chk("e_addr", imem_addr, 32'h300);
    drive(1'b1, 1'b0, '0);
    wait_valid("e_valid2");
    chk("e_pc", pc_out, 32'h300);

    // Fetch PC wraps past the top of the address space
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    seen0 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h0) seen0 = 1;
      drive(1'b1, 1'b0, '0);
    end
    tick();
    chk("f_wrap", {31'b0, seen0}, 32'd1);

    // Randomized traffic: ready, memory latency and redirects
    lat_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, tgt);
      tick();
    end
    lat_rand = 0;

    // Reset asserted while a request is outstanding
    lat_cfg = 6;
    n = 0;
    drive(1'b1, 1'b0, '0);
    tick();
    while (!(imem_req && mem_pend) && n < 40) begin
      drive(1'b1, 1'b0, '0);
      tick();
      n++;
    end
    chk("h_pre_req", {31'b0, imem_req}, 32'd1);
    do_reset();
    lat_cfg = 0;
    drive(1'b1, 1'b0, '0);
    tick();
    chk("h_req", {31'b0, imem_req}, 32'd1);
    chk("h_addr", imem_addr, RST_PC);
    drive(1'b1, 1'b0, '0);
    wait_valid("h_valid");
    chk("h_pc", pc_out, RST_PC);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0);
      tick();
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", fetch_count, pops_seen);
    chk("perf_flush", {16'b0, flush_count}, flushes_seen);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the fetch PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a small FIFO and presents the head instruction with pre-split op/cond/funct/rd fields to control/decode through a valid/ready handshake.
- Takes the branch redirect (pc_src plus target) back from the execute side and flushes wrong-path work.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction width (field slicing assumes 32)
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  memory request, held until imem_ack
imem_addr  output  ADDR_W  request address, stable while imem_req=1
imem_ack  input  1  request complete; imem_rdata valid this cycle
imem_rdata  input  DATA_W  fetched word
pc_src  input  1  redirect strobe from cond logic
branch_target  input  ADDR_W  redirect address, sampled when pc_src=1
inst_valid  output  1  head instruction available
inst_ready  input  1  downstream accepts head
instr  output  DATA_W  head instruction word
pc_out  output  ADDR_W  address of head instruction
cond  output  4  instr[31:28]
op  output  2  instr[27:26]
funct  output  6  instr[25:20]
rd  output  4  instr[15:12]

Behaviour:
- Reset (async assert, sync-release use): fetch_pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0; instr/pc_out/fields=0.
- While inst_valid=0, instr/pc_out/fields are driven 0.
- FSM states: IDLE (nothing outstanding), BUSY (request outstanding, result kept), DROP (request outstanding, result discarded).
- IDLE->BUSY: when count < FIFO_DEPTH and no redirect this cycle; imem_req=1, imem_addr=fetch_pc (registered). Request issues in the first cycle after reset release.
- BUSY, imem_ack=1, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping mod 2^ADDR_W. Issue the next request back-to-back (stay BUSY) if space remains after this push and pop, else go to IDLE.
- BUSY, imem_ack=0: hold imem_req and imem_addr unchanged.
- Redirect (pc_src=1) in any state:
  - FIFO flushed same edge; fetch_pc=branch_target.
  - Any pop in that cycle is ignored; inst_valid=0 next cycle.
- Redirect while BUSY and imem_ack=0: go to DROP; imem_req stays 1 at the old address.
- Redirect while BUSY and imem_ack=1: returned word discarded; go to IDLE.
- DROP: hold the request until imem_ack, discard data, then go to IDLE. A further redirect in DROP only updates fetch_pc.
- Pop when inst_valid && inst_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Push into a full FIFO cannot occur, because requests issue only with space.
- Latency: ack in cycle N gives inst_valid=1 in cycle N+1. Zero-wait memory with inst_ready=1 sustains one instruction per cycle only when FIFO_DEPTH>=2.
- Program order is preserved; no instruction is duplicated or dropped except by redirect flush.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds output fetch_count [31:0], counting accepted pops (inst_valid && inst_ready), and output flush_count [15:0], counting redirect cycles.
  - Both counters reset to 0 and saturate at all-ones.
- When undefined: neither port nor any logic exists; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory returning addr as data, inst_ready=1 -> imem_addr 0,4,8,...; instr 0x0,0x4,0x8 on consecutive cycles with pc_out equal to instr.
- Word 0xE0812003 at addr 0 -> cond=0xE, op=0, funct=0x08, rd=2.
- inst_ready=0 for 5 cycles -> exactly FIFO_DEPTH words buffered and imem_req=0; on ready, head pc 0x0 first and no loss.
- pc_src=1, branch_target=0x100 while a request to 0x8 waits 3 cycles for ack -> DROP, 0x8 data discarded, next imem_addr=0x100, first valid pc_out=0x100.
- pc_src coincident with imem_ack and a pop -> FIFO empty next cycle, inst_valid=0, fetch_pc=target.
- RESET_PC=0xFFFFFFFC -> second request at 0x00000000; reset asserted mid-BUSY -> imem_req=0 immediately and fetch restarts at RESET_PC.
